// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, writer state encoding and the pixel address helper.
package vga_pkg;

    localparam int H_RES           = 256;
    localparam int V_RES           = 144;
    localparam int BYTES_PER_PIXEL = 4;
    localparam int FB_DEPTH        = H_RES * V_RES;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_WRITE    = 2'd1,
        ST_SKIP_EOL = 2'd2
    } fb_state_t;

    // Byte address of pixel (col,row); all arithmetic in 32 bits.
    function automatic logic [31:0] pix_byte_addr(input logic [31:0] col,
                                                  input logic [31:0] row,
                                                  input logic [31:0] hres);
        return (row * hres + col) * BYTES_PER_PIXEL;
    endfunction

endpackage

// File: rtl/fb_pix_counter.sv
// Column/row position counter for the framebuffer writer.
// Priority: restart > eol > adv. restart places the position just after
// pixel (0,0) because the restarting beat itself is written at (0,0).
module fb_pix_counter
    import vga_pkg::*;
#(
    parameter int H_RES = 256,
    parameter int V_RES = 144,
    parameter int CW    = (H_RES > 1) ? $clog2(H_RES) : 1,
    parameter int RW    = (V_RES > 1) ? $clog2(V_RES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          adv,
    input  logic          eol,
    input  logic          restart,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last_col,
    output logic          last_row
);

    localparam logic [CW-1:0] COL_MAX   = CW'(H_RES - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(V_RES - 1);
    localparam logic [CW-1:0] COL_START = (H_RES > 1) ? CW'(1) : CW'(0);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    assign col      = r_col;
    assign row      = r_row;
    assign last_col = (r_col == COL_MAX);
    assign last_row = (r_row == ROW_MAX);

    // Position update; row wraps to 0 after the last line of the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (restart) begin
            r_col <= COL_START;
            r_row <= '0;
        end else if (eol) begin
            r_col <= '0;
            r_row <= last_row ? '0 : r_row + RW'(1);
        end else if (adv) begin
            r_col <= last_col ? '0 : r_col + CW'(1);
        end
    end

endmodule

// File: rtl/fb_stream_writer.sv
// AXI-Stream video to BRAM framebuffer writer.
// Optional feature: define FB_WRITER_ERR_CNT_EN to build the saturating
// line/frame error counter; otherwise err_count is tied to zero.
module fb_stream_writer #(
    parameter int H_RES = vga_pkg::H_RES,
    parameter int V_RES = vga_pkg::V_RES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_din,
    output logic [3:0]  bram_we,
    output logic        bram_en,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    output logic [15:0] err_count
);
    import vga_pkg::*;

    localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;

    fb_state_t   r_state, w_state_next;
    logic        w_accept;
    logic        w_wr, w_line_err, w_frame_err, w_frame_done;
    logic        w_adv, w_eol, w_restart;
    logic [31:0] w_addr;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic        w_last_col, w_last_row;

    logic        r_bram_en, r_frame_done, r_line_err, r_frame_err;
    logic [31:0] r_bram_addr, r_bram_din;

    // Ready follows enable only; it is forced low while reset is held.
    assign s_axis_tready = enable & ~reset;
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    fb_pix_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .CW    (CW),
        .RW    (RW)
    ) u_pix_counter (
        .clk      (clk),
        .reset    (reset),
        .adv      (w_adv),
        .eol      (w_eol),
        .restart  (w_restart),
        .col      (w_col),
        .row      (w_row),
        .last_col (w_last_col),
        .last_row (w_last_row)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_WAIT_SOF;
        else       r_state <= w_state_next;
    end

    // Next-state, counter control and write decision for the accepted beat.
    always_comb begin
        w_state_next = r_state;
        w_wr         = 1'b0;
        w_line_err   = 1'b0;
        w_frame_err  = 1'b0;
        w_frame_done = 1'b0;
        w_adv        = 1'b0;
        w_eol        = 1'b0;
        w_restart    = 1'b0;
        w_addr       = pix_byte_addr(32'(w_col), 32'(w_row), 32'(H_RES));
        if (w_accept) begin
            if (s_axis_tuser) begin
                // Start of frame wins over tlast in every state.
                w_wr         = 1'b1;
                w_addr       = '0;
                w_restart    = 1'b1;
                w_frame_err  = (r_state != ST_WAIT_SOF) &&
                               !((w_col == '0) && (w_row == '0));
                w_state_next = ST_WRITE;
            end else begin
                case (r_state)
                    ST_WRITE: begin
                        w_wr = 1'b1;
                        if (s_axis_tlast) begin
                            w_eol      = 1'b1;
                            w_line_err = !w_last_col;
                            if (w_last_row) begin
                                w_frame_done = 1'b1;
                                w_state_next = ST_WAIT_SOF;
                            end
                        end else if (w_last_col) begin
                            // Line too long: keep position, drop beats up to tlast.
                            w_line_err   = 1'b1;
                            w_state_next = ST_SKIP_EOL;
                        end else begin
                            w_adv = 1'b1;
                        end
                    end
                    ST_SKIP_EOL: begin
                        if (s_axis_tlast) begin
                            w_eol = 1'b1;
                            if (w_last_row) begin
                                w_frame_done = 1'b1;
                                w_state_next = ST_WAIT_SOF;
                            end else begin
                                w_state_next = ST_WRITE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered write port and status pulses, one cycle after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bram_en    <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_din   <= '0;
            r_frame_done <= 1'b0;
            r_line_err   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_bram_en    <= w_wr;
            r_frame_done <= w_frame_done;
            r_line_err   <= w_line_err;
            r_frame_err  <= w_frame_err;
            if (w_wr) begin
                r_bram_addr <= w_addr;
                r_bram_din  <= s_axis_tdata;
            end
        end
    end

    assign bram_en    = r_bram_en;
    assign bram_we    = {4{r_bram_en}};
    assign bram_addr  = r_bram_addr;
    assign bram_din   = r_bram_din;
    assign frame_done = r_frame_done;
    assign line_err   = r_line_err;
    assign frame_err  = r_frame_err;

`ifdef FB_WRITER_ERR_CNT_EN
    logic [15:0] r_err_count;

    // Saturating count of error pulses, updated alongside the pulse itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if ((w_line_err || w_frame_err) && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_fb_stream_writer.sv
// Scoreboard bench for fb_stream_writer: expected writes are queued as beats
// are driven and checked when the BRAM strobe appears.
module tb_fb_stream_writer;

    localparam int HR = 256;
    localparam int VR = 144;
`ifdef FB_WRITER_ERR_CNT_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
    logic [31:0] bram_addr, bram_din;
    logic [3:0]  bram_we;
    logic        bram_en, frame_done, line_err, frame_err;
    logic [15:0] err_count;

    fb_stream_writer dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .bram_addr     (bram_addr),
        .bram_din      (bram_din),
        .bram_we       (bram_we),
        .bram_en       (bram_en),
        .frame_done    (frame_done),
        .line_err      (line_err),
        .frame_err     (frame_err),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fd;
        logic        le;
        logic        fe;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int checks = 0;
    int failures = 0;
    int writes_seen = 0, fd_seen = 0, le_seen = 0, fe_seen = 0;

    // Monitor: every write is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (bram_en) begin
                writes_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    if (failures < 20) $display("FAIL unexpected_write addr=%h data=%h", bram_addr, bram_din);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bram_addr !== mon_e.addr || bram_din !== mon_e.data || bram_we !== 4'hF) begin
                        failures++;
                        if (failures < 20)
                            $display("FAIL write addr=%h data=%h we=%h required addr=%h data=%h we=f",
                                     bram_addr, bram_din, bram_we, mon_e.addr, mon_e.data);
                    end
                    checks++;
                    if ({frame_done, line_err, frame_err} !== {mon_e.fd, mon_e.le, mon_e.fe}) begin
                        failures++;
                        if (failures < 20)
                            $display("FAIL pulses addr=%h fd/le/fe=%b%b%b required %b%b%b", bram_addr,
                                     frame_done, line_err, frame_err, mon_e.fd, mon_e.le, mon_e.fe);
                    end
                end
            end else begin
                checks++;
                if (bram_we !== 4'h0 || frame_done !== 1'b0 || line_err !== 1'b0 || frame_err !== 1'b0) begin
                    failures++;
                    if (failures < 20)
                        $display("FAIL idle_strobe we=%h fd/le/fe=%b%b%b required 0", bram_we,
                                 frame_done, line_err, frame_err);
                end
            end
            if (frame_done === 1'b1) fd_seen++;
            if (line_err === 1'b1)   le_seen++;
            if (frame_err === 1'b1)  fe_seen++;
        end
    end

    function automatic void push_exp(input int addr, input logic [31:0] d,
                                     input logic fd, input logic le, input logic fe);
        exp_t e;
        e.addr = 32'(addr);
        e.data = d;
        e.fd   = fd;
        e.le   = le;
        e.fe   = fe;
        exp_q.push_back(e);
    endfunction

    task automatic drive_beat(input logic [31:0] d, input logic u, input logic l);
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        enable        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        repeat (3) @(posedge clk);
        exp_q.delete();
        #1 reset = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        enable        = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b required 0", s_axis_tready); end
        checks++; if (bram_en !== 1'b0)       begin failures++; $display("FAIL reset_en got=%b required 0", bram_en); end
        checks++; if (bram_we !== 4'h0)       begin failures++; $display("FAIL reset_we got=%h required 0", bram_we); end
        checks++; if (bram_addr !== 32'h0)    begin failures++; $display("FAIL reset_addr got=%h required 0", bram_addr); end
        checks++; if (bram_din !== 32'h0)     begin failures++; $display("FAIL reset_din got=%h required 0", bram_din); end
        checks++; if (frame_done !== 1'b0)    begin failures++; $display("FAIL reset_fd got=%b required 0", frame_done); end
        checks++; if (line_err !== 1'b0)      begin failures++; $display("FAIL reset_le got=%b required 0", line_err); end
        checks++; if (frame_err !== 1'b0)     begin failures++; $display("FAIL reset_fe got=%b required 0", frame_err); end
        checks++; if (err_count !== 16'h0)    begin failures++; $display("FAIL reset_errcnt got=%h required 0", err_count); end
        $display("test_reset done");
    endtask

    task automatic test_clean_frame();
        logic [31:0] d;
        int w0, f0;
        do_reset();
        w0 = writes_seen;
        f0 = fd_seen;
        for (int r = 0; r < VR; r++) begin
            for (int c = 0; c < HR; c++) begin
                d = $urandom;
                push_exp(4 * (r * HR + c), d, (r == VR - 1) && (c == HR - 1), 1'b0, 1'b0);
                drive_beat(d, (r == 0) && (c == 0), c == HR - 1);
            end
        end
        // Back in WAIT_SOF: a beat without tuser must be dropped.
        drive_beat(32'h12345678, 1'b0, 1'b0);
        drain("clean");
        checks++; if (writes_seen - w0 != HR * VR) begin failures++; $display("FAIL clean_writes got=%0d required %0d", writes_seen - w0, HR * VR); end
        checks++; if (fd_seen - f0 != 1) begin failures++; $display("FAIL clean_frame_done got=%0d required 1", fd_seen - f0); end
        checks++; if (err_count !== 16'h0) begin failures++; $display("FAIL clean_errcnt got=%0d required 0", err_count); end
        $display("test_clean_frame done writes=%0d", writes_seen - w0);
    endtask

    task automatic test_early_eol();
        logic [31:0] d;
        int l0;
        do_reset();
        l0 = le_seen;
        for (int c = 0; c < 100; c++) begin
            d = $urandom;
            push_exp(4 * c, d, 1'b0, c == 99, 1'b0);
            drive_beat(d, c == 0, c == 99);
        end
        for (int c = 0; c < 3; c++) begin
            d = $urandom;
            push_exp(32'h400 + 4 * c, d, 1'b0, 1'b0, 1'b0);
            drive_beat(d, 1'b0, 1'b0);
        end
        drain("early_eol");
        checks++; if (le_seen - l0 != 1) begin failures++; $display("FAIL early_eol_line_err got=%0d required 1", le_seen - l0); end
        checks++; if (err_count !== 16'(ERR_EN)) begin failures++; $display("FAIL early_eol_errcnt got=%0d required %0d", err_count, ERR_EN); end
        $display("test_early_eol done");
    endtask

    task automatic test_overlong();
        logic [31:0] d;
        int l0, w0;
        do_reset();
        l0 = le_seen;
        w0 = writes_seen;
        for (int i = 0; i < 260; i++) begin
            d = $urandom;
            if (i < HR) push_exp(4 * i, d, 1'b0, i == HR - 1, 1'b0);
            drive_beat(d, i == 0, i == 259);
        end
        d = $urandom;
        push_exp(32'h400, d, 1'b0, 1'b0, 1'b0);
        drive_beat(d, 1'b0, 1'b0);
        drain("overlong");
        checks++; if (le_seen - l0 != 1) begin failures++; $display("FAIL overlong_line_err got=%0d required 1", le_seen - l0); end
        checks++; if (writes_seen - w0 != HR + 1) begin failures++; $display("FAIL overlong_writes got=%0d required %0d", writes_seen - w0, HR + 1); end
        $display("test_overlong done");
    endtask

    task automatic test_restart();
        logic [31:0] d;
        int f0;
        do_reset();
        f0 = fe_seen;
        for (int i = 0; i < 4999; i++) begin
            d = $urandom;
            push_exp(4 * i, d, 1'b0, 1'b0, 1'b0);
            drive_beat(d, i == 0, (i % HR) == HR - 1);
        end
        d = $urandom;
        push_exp(0, d, 1'b0, 1'b0, 1'b1);
        drive_beat(d, 1'b1, 1'b0);
        d = $urandom;
        push_exp(4, d, 1'b0, 1'b0, 1'b0);
        drive_beat(d, 1'b0, 1'b0);
        drain("restart");
        checks++; if (fe_seen - f0 != 1) begin failures++; $display("FAIL restart_frame_err got=%0d required 1", fe_seen - f0); end
        checks++; if (err_count !== 16'(ERR_EN)) begin failures++; $display("FAIL restart_errcnt got=%0d required %0d", err_count, ERR_EN); end
        $display("test_restart done");
    endtask

    task automatic test_stall_and_reset();
        logic [31:0] d;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            d = $urandom;
            push_exp(4 * c, d, 1'b0, 1'b0, 1'b0);
            drive_beat(d, c == 0, 1'b0);
        end
        enable        = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hBAD0BAD0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL stall_tready cycle=%0d got=%b required 0", k, s_axis_tready); end
        end
        s_axis_tvalid = 1'b0;
        enable        = 1'b1;
        for (int c = 10; c < 13; c++) begin
            d = $urandom;
            push_exp(4 * c, d, 1'b0, 1'b0, 1'b0);
            drive_beat(d, 1'b0, 1'b0);
        end
        drain("stall");
        // Accept one more beat, then reset while its write strobe is live.
        d = $urandom;
        push_exp(4 * 13, d, 1'b0, 1'b0, 1'b0);
        drive_beat(d, 1'b0, 1'b0);
        checks++; if (bram_en !== 1'b1) begin failures++; $display("FAIL pending_write_en got=%b required 1", bram_en); end
        reset = 1'b1;
        #1;
        exp_q.delete();
        checks++; if (bram_en !== 1'b0 || bram_we !== 4'h0) begin failures++; $display("FAIL async_reset_en en=%b we=%h required 0", bram_en, bram_we); end
        checks++; if (bram_addr !== 32'h0 || bram_din !== 32'h0) begin failures++; $display("FAIL async_reset_data addr=%h din=%h required 0", bram_addr, bram_din); end
        checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL async_reset_tready got=%b required 0", s_axis_tready); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        d = $urandom;
        push_exp(0, d, 1'b0, 1'b0, 1'b0);
        drive_beat(d, 1'b1, 1'b0);
        d = $urandom;
        push_exp(4, d, 1'b0, 1'b0, 1'b0);
        drive_beat(d, 1'b0, 1'b0);
        drain("post_reset");
        $display("test_stall_and_reset done");
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_early_eol();
        test_overlong();
        test_restart();
        test_stall_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_stream_writer.md
FB_STREAM_WRITER -- requirements
Module: fb_stream_writer

Interface
REQ-001 H_RES, default 256, active pixels per line written to the framebuffer.
REQ-002 V_RES, default 144, active lines per frame written to the framebuffer.
REQ-003 clk  input  1  single clock; every register is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  level; when low, the block stalls intake.
REQ-006 s_axis_tdata  input  32  one pixel per beat.
REQ-007 s_axis_tvalid / s_axis_tready  input / output  1 each  AXI-Stream handshake.
REQ-008 s_axis_tuser  input  1  start-of-frame flag on the first pixel of a frame.
REQ-009 s_axis_tlast  input  1  end-of-line flag on the last pixel of each line.
REQ-010 bram_addr  output  32  byte address, equal to 4*(row*H_RES+col).
REQ-011 bram_din / bram_we / bram_en  output  32 / 4 / 1  BRAM write port.
REQ-012 frame_done  output  1  one-cycle pulse when a frame completes.
REQ-013 line_err / frame_err  output  1 each  one-cycle error pulses.
REQ-014 err_count  output  16  error counter (see Configuration).

Function
REQ-015 States:
- WAIT_SOF: waiting for a start-of-frame beat.
- WRITE: storing pixels.
- SKIP_EOL: discarding the rest of an overlong line.
REQ-016 Handshake:
- s_axis_tready SHALL equal enable and SHALL NOT depend on state.
- A beat is accepted when tvalid && tready.
REQ-017 WAIT_SOF:
- An accepted beat with tuser=0 is discarded and causes no write.
- An accepted beat with tuser=1 is written at col=0,row=0; the block then enters WRITE with col=1.
REQ-018 WRITE, accepted beat: the block writes the pixel at (col,row) and then advances col.
REQ-019 Write timing:
- bram_en, bram_we=4'hF, bram_addr and bram_din SHALL be registered and asserted exactly one cycle after acceptance.
- Outside that cycle, bram_en=0 and bram_we=0.
REQ-020 Normal end of line: tlast=1 with col==H_RES-1 sets col=0 and row=row+1.
REQ-021 Early end of line:
- Condition: tlast=1 with col<H_RES-1.
- The beat is written, line_err pulses, and col=0, row+1.
- The remaining pixels of that line are left unwritten.
REQ-022 Overlong line:
- Condition: col==H_RES-1 with tlast=0.
- The beat is written, line_err pulses, and the block enters SKIP_EOL.
- SKIP_EOL discards beats until an accepted tlast=1, then sets col=0, row+1 and returns to WRITE.
REQ-023 Frame end:
- A row increment from V_RES-1 (by REQ-020, 021 or 022) pulses frame_done.
- The pulse occurs in the same cycle as the final write strobe.
- The block then returns to WAIT_SOF.
REQ-024 Mid-frame restart:
- Condition: tuser=1 accepted in WRITE or SKIP_EOL at any position other than col=0,row=0.
- frame_err pulses and the beat is written at address 0.
- The block continues in WRITE with col=1,row=0.
REQ-025 Simultaneous tuser=1 and tlast=1: the tuser rule takes priority and tlast is ignored.
REQ-026 Counter width: col and row are $clog2 of H_RES and V_RES wide respectively, and SHALL never exceed H_RES-1 and V_RES-1.
REQ-027 Address arithmetic: the address is computed in 32 bits; the maximum byte address is 4*(H_RES*V_RES-1).
REQ-028 Stall: with enable=0, no beat is accepted and state, col and row hold.

Reset
REQ-029 Reset SHALL be asynchronous and take effect immediately, including mid-frame.
REQ-030 Values during reset:
- state=WAIT_SOF, col=0, row=0.
- s_axis_tready=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0.
- frame_done=0, line_err=0, frame_err=0, err_count=0.
REQ-031 A write pending at reset assertion SHALL be dropped.

Configuration
REQ-032 FB_WRITER_ERR_CNT_EN defined:
- err_count increments on every line_err or frame_err pulse.
- It saturates at 16'hFFFF.
- It clears only on reset.
REQ-033 FB_WRITER_ERR_CNT_EN undefined: err_count is constant 0, and no counter register is synthesised.

Structure
REQ-034 Package vga_pkg SHALL hold:
- H_RES/V_RES defaults (256/144).
- BYTES_PER_PIXEL=4.
- FB_DEPTH=H_RES*V_RES.
- The state enum type.
REQ-035 The col/row counter pair SHALL be a sub-module fb_pix_counter, with:
- inputs adv, eol, restart;
- outputs col, row, last_col, last_row.

Verification
REQ-036 Clean frame: SOF, then 144 lines of 256 beats with correct tlast -> 36864 writes with addresses 0..0x23FFC in order, and one frame_done pulse aligned with the write to 0x23FFC.
REQ-037 Early EOL: line 0 ends with tlast after 100 beats -> line_err pulses once; the next beat is written at 0x400; err_count=1 if the macro is enabled.
REQ-038 Overlong line: line 0 has 260 beats with tlast on beat 260 -> 256 writes, 4 discarded beats, one line_err; the next beat is written at 0x400.
REQ-039 Restart: tuser on beat 5000 -> frame_err pulses and that beat is written at address 0; the next beat is written at 0x4.
REQ-040 Stall and reset: enable low for 10 cycles mid-line -> no writes, position preserved. Reset asserted mid-frame -> outputs 0 immediately; a following SOF beat is written at address 0.
